// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: duty-cycle sequencer for a PERIOD-step PWM channel.
// The live duty walks one step toward the setpoint every STEP_PERIODS
// periods. Duty changes only at a period boundary, so every PWM period
// uses a single duty value.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | channel off: cnt frozen at 0, duty forced to 0, pwm_out low
// RAMP  | counting; duty steps toward setpoint at paced boundaries
// HOLD  | counting; duty equals setpoint and stays constant
module pwm_ramp_ctrl #(
  parameter int PERIOD       = 10,
  parameter int DUTY_W       = 4,
  parameter int STEP_PERIODS = 2,
  parameter int SP_RESET     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              inc_req,
  input  logic              dec_req,
  input  logic              target_valid,
  input  logic [DUTY_W-1:0] target,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty,
  output logic [DUTY_W-1:0] setpoint,
  output logic              period_start,
  output logic              busy
);

  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] SP_INIT  = DUTY_W'(SP_RESET);
  localparam logic [SW-1:0]     STEP_LAST = SW'(STEP_PERIODS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [DUTY_W-1:0] cnt;
  logic [SW-1:0]     step_cnt;
  logic [DUTY_W-1:0] cnt_next;
  logic [DUTY_W-1:0] duty_toward;
  logic              boundary;

  // Period counter successor, boundary flag and the one-step move toward the setpoint.
  always_comb begin
    boundary    = (cnt == CNT_LAST);
    cnt_next    = boundary ? '0 : cnt + DUTY_W'(1);
    duty_toward = (setpoint > duty) ? duty + DUTY_W'(1) : duty - DUTY_W'(1);
  end

  // Setpoint register: target load beats inc/dec; inc with dec cancels; saturate at 0 and PERIOD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      setpoint <= SP_INIT;
    end else if (target_valid) begin
      setpoint <= (target > DUTY_MAX) ? DUTY_MAX : target;
    end else if (inc_req && dec_req) begin
      setpoint <= setpoint;
    end else if (inc_req) begin
      if (setpoint < DUTY_MAX) setpoint <= setpoint + DUTY_W'(1);
    end else if (dec_req) begin
      if (setpoint != '0) setpoint <= setpoint - DUTY_W'(1);
    end
  end

  // Sequencer: state, period counter, step pacing counter and live duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      step_cnt <= '0;
      duty     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt      <= '0;
          step_cnt <= '0;
          duty     <= '0;
          if (en) state <= RAMP;
        end
        RAMP: begin
          if (!en) begin
            state    <= IDLE;
            cnt      <= '0;
            step_cnt <= '0;
            duty     <= '0;
          end else begin
            cnt <= cnt_next;
            if (boundary) begin
              if (duty == setpoint) begin
                state    <= HOLD;
                step_cnt <= '0;
              end else if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                duty     <= duty_toward;
                if (duty_toward == setpoint) state <= HOLD;
              end else begin
                step_cnt <= step_cnt + SW'(1);
              end
            end
          end
        end
        HOLD: begin
          if (!en) begin
            state    <= IDLE;
            cnt      <= '0;
            step_cnt <= '0;
            duty     <= '0;
          end else begin
            cnt <= cnt_next;
            if (duty != setpoint) begin
              state    <= RAMP;
              step_cnt <= '0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          step_cnt <= '0;
          duty     <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from flops only, so no input reaches an output combinationally.
  always_comb begin
    pwm_out      = (state != IDLE) && (cnt < duty);
    period_start = (state != IDLE) && (cnt == '0);
    busy         = (state == RAMP);
  end

endmodule
